// File: rtl/gs_pkg.sv
// Shared phase encoding and width helper for the Gauss-Seidel operand store.
package gs_pkg;

  localparam logic [1:0] GS_LOAD = 2'd0;
  localparam logic [1:0] GS_ITER = 2'd1;
  localparam logic [1:0] GS_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_LOAD = GS_LOAD,
    ST_ITER = GS_ITER,
    ST_DONE = GS_DONE
  } gs_phase_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gs_conv_monitor.sv
// Per-sweep maximum of |x_new - x_old| with saturation, compared against a
// tolerance on the wrap beat. Only built when GS_CONV_EN is defined.
module gs_conv_monitor #(
  parameter int X_W = 32
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic           clear_in,
  input  logic           beat_in,
  input  logic           wrap_in,
  input  logic [X_W-1:0] x_in,
  input  logic [X_W-1:0] slot0_in,
  input  logic [X_W-2:0] tol_in,
  output logic           hit_out
);

  logic [X_W-2:0] r_max;
  logic [X_W:0]   w_diff;
  logic [X_W:0]   w_abs;
  logic [X_W-2:0] w_mag;
  logic [X_W-2:0] w_max_beat;

  // One extra bit keeps opposite-sign extremes from wrapping.
  assign w_diff     = {x_in[X_W-1], x_in} - {slot0_in[X_W-1], slot0_in};
  assign w_abs      = w_diff[X_W] ? ('0 - w_diff) : w_diff;
  assign w_mag      = (w_abs[X_W] | w_abs[X_W-1]) ? '1 : w_abs[X_W-2:0];
  assign w_max_beat = (w_mag > r_max) ? w_mag : r_max;
  assign hit_out    = wrap_in && (w_max_beat <= tol_in);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_max <= '0;
    end else if (clear_in || wrap_in) begin
      r_max <= '0;
    end else if (beat_in) begin
      r_max <= w_max_beat;
    end
  end

endmodule

// File: rtl/gs_neighbor_regfile.sv
// Circular b/x operand store presenting K zero-masked neighbours per row.
// Define GS_CONV_EN to add the convergence monitor, tol_in and conv_out.
module gs_neighbor_regfile
  import gs_pkg::*;
#(
  parameter int N      = 16,
  parameter int K      = 3,
  parameter int B_W    = 16,
  parameter int X_W    = 32,
  parameter int ITER_W = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  clear_in,
  input  logic                  load_valid_in,
  input  logic [B_W-1:0]        b_in,
  input  logic                  x_valid_in,
  input  logic [X_W-1:0]        x_in,
  output logic [1:0]            phase_out,
  output logic [clog2(N)-1:0]   row_out,
  output logic [ITER_W-1:0]     iter_out,
  output logic [B_W-1:0]        b_out,
  output logic [K*X_W-1:0]      x_lo_out,
`ifdef GS_CONV_EN
  input  logic [X_W-2:0]        tol_in,
  output logic                  conv_out,
`endif
  output logic [K*X_W-1:0]      x_hi_out
);

  // state   | meaning
  // ST_LOAD | accepting b beats, row counts loaded entries
  // ST_ITER | accepting x updates, b rotates with the row
  // ST_DONE | converged, holds until clear or reset

  localparam int                ROW_W    = clog2(N);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(N - 1);
  localparam logic [ITER_W-1:0] ITER_MAX = '1;

  gs_phase_e         r_phase;
  gs_phase_e         w_phase_nxt;
  logic [ROW_W-1:0]  r_row;
  logic [ITER_W-1:0] r_iter;
  logic [X_W-1:0]    r_x [N];
  logic [B_W-1:0]    r_b [N];

  logic w_row_last;
  logic w_load_beat;
  logic w_iter_beat;
  logic w_wrap;
  logic w_conv_hit;

  assign w_row_last = (r_row == ROW_LAST);
  assign w_wrap     = w_iter_beat && w_row_last;

  always_comb begin
    w_phase_nxt = r_phase;
    w_load_beat = 1'b0;
    w_iter_beat = 1'b0;
    if (clear_in) begin
      w_phase_nxt = ST_LOAD;
    end else begin
      case (r_phase)
        ST_LOAD: begin
          w_load_beat = load_valid_in;
          if (load_valid_in && w_row_last) w_phase_nxt = ST_ITER;
        end
        ST_ITER: begin
          w_iter_beat = x_valid_in;
          if (x_valid_in && w_row_last && w_conv_hit) w_phase_nxt = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_phase <= ST_LOAD;
      r_row   <= '0;
      r_iter  <= '0;
      for (int i = 0; i < N; i++) r_x[i] <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      if (clear_in) begin
        r_row  <= '0;
        r_iter <= '0;
        for (int i = 0; i < N; i++) r_x[i] <= '0;
      end else begin
        // N is a power of two, so the row counter wraps on its own.
        if (w_load_beat || w_iter_beat) r_row <= r_row + ROW_W'(1);
        if (w_wrap && (r_iter != ITER_MAX)) r_iter <= r_iter + ITER_W'(1);
        if (w_iter_beat) begin
          for (int i = 0; i < N - 1; i++) r_x[i] <= r_x[i+1];
          r_x[N-1] <= x_in;
        end
      end
    end
  end

  // b is deliberately not reset; it is always reloaded before use.
  always_ff @(posedge clk_in) begin
    if (w_load_beat || w_iter_beat) begin
      for (int i = 0; i < N - 1; i++) r_b[i] <= r_b[i+1];
      r_b[N-1] <= w_load_beat ? b_in : r_b[0];
    end
  end

  always_comb begin
    x_lo_out = '0;
    x_hi_out = '0;
    for (int k = 1; k <= K; k++) begin
      if (int'(r_row) >= k)    x_lo_out[(k-1)*X_W +: X_W] = r_x[N-k];
      if (int'(r_row) + k < N) x_hi_out[(k-1)*X_W +: X_W] = r_x[k];
    end
  end

`ifdef GS_CONV_EN
  logic r_conv;

  gs_conv_monitor #(.X_W(X_W)) u_conv (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clear_in (clear_in),
    .beat_in  (w_iter_beat),
    .wrap_in  (w_wrap),
    .x_in     (x_in),
    .slot0_in (r_x[0]),
    .tol_in   (tol_in),
    .hit_out  (w_conv_hit)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_conv <= 1'b0;
    end else if (clear_in) begin
      r_conv <= 1'b0;
    end else if (w_conv_hit) begin
      r_conv <= 1'b1;
    end
  end

  assign conv_out = r_conv;
`else
  assign w_conv_hit = 1'b0;
`endif

  assign phase_out = r_phase;
  assign row_out   = r_row;
  assign iter_out  = r_iter;
  assign b_out     = r_b[0];

endmodule
